// File: rtl/vlogic_pkg.sv
// Shared encodings and width helpers for the vector bitwise-logic unit.
package vlogic_pkg;

  typedef enum logic [2:0] {
    VLOG_AND  = 3'b000,
    VLOG_OR   = 3'b001,
    VLOG_XOR  = 3'b010,
    VLOG_ANDN = 3'b011,
    VLOG_ORN  = 3'b100,
    VLOG_XNOR = 3'b101,
    VLOG_NAND = 3'b110,
    VLOG_NOR  = 3'b111
  } vlog_op_e;

  localparam logic SEW_8  = 1'b0;
  localparam logic SEW_32 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  function automatic int unsigned calc_mask_w(input int unsigned vlen_bits,
                                              input int unsigned max_lmul);
    return max_lmul * vlen_bits / 8;
  endfunction

  function automatic int unsigned calc_vl_w(input int unsigned mask_w);
    return $clog2(mask_w + 1);
  endfunction

endpackage

// File: rtl/vlogic_lane.sv
// Combinational datapath for one register chunk: logic op plus per-byte
// merge with the old destination according to vl and v0 masking.
module vlogic_lane
  import vlogic_pkg::*;
#(
  parameter int unsigned VLEN_BITS = 128,
  parameter int unsigned MASK_W    = 64,
  parameter int unsigned VL_W      = 7
) (
  input  logic [2:0]           op,
  input  logic                 sew,
  input  logic [1:0]           chunk,
  input  logic [VL_W-1:0]      vl,
  input  logic                 vm,
  input  logic [MASK_W-1:0]    mask,
  input  logic [VLEN_BITS-1:0] vs2,
  input  logic [VLEN_BITS-1:0] vs1,
  input  logic [VLEN_BITS-1:0] old,
  output logic [VLEN_BITS-1:0] res
);

  localparam int unsigned NB  = VLEN_BITS / 8;
  localparam int unsigned MIW = $clog2(MASK_W);

  logic [VLEN_BITS-1:0] opres;
  logic [NB-1:0]        be;

  always_comb begin
    opres = '0;
    case (vlog_op_e'(op))
      VLOG_AND:  opres = vs2 & vs1;
      VLOG_OR:   opres = vs2 | vs1;
      VLOG_XOR:  opres = vs2 ^ vs1;
      VLOG_ANDN: opres = vs2 & ~vs1;
      VLOG_ORN:  opres = vs2 | ~vs1;
      VLOG_XNOR: opres = ~(vs2 ^ vs1);
      VLOG_NAND: opres = ~(vs2 & vs1);
      VLOG_NOR:  opres = ~(vs2 | vs1);
      default:   opres = '0;
    endcase
  end

  // 32-bit elements: four consecutive bytes share one global element index
  always_comb begin
    int unsigned g;
    be  = '0;
    res = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (sew == SEW_32)
        g = 32'(chunk) * (NB / 4) + b / 4;
      else
        g = 32'(chunk) * NB + b;
      be[b] = (g < 32'(vl)) && (vm || mask[MIW'(g)]);
      res[b*8 +: 8] = be[b] ? opres[b*8 +: 8] : old[b*8 +: 8];
    end
  end

endmodule

// File: rtl/vlogic_unit.sv
// Multi-cycle vector bitwise-logic unit: latches a request, then writes one
// VLEN_BITS chunk of the registered result per cycle until the group is done.
module vlogic_unit
  import vlogic_pkg::*;
#(
  parameter int unsigned VLEN_BITS = 128,
  parameter int unsigned MAX_LMUL  = 4,
  parameter int unsigned MASK_W    = calc_mask_w(VLEN_BITS, MAX_LMUL),
  parameter int unsigned VL_W      = calc_vl_w(MASK_W)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    op,
  input  logic                          sew,
  input  logic [1:0]                    nreg,
  input  logic [VL_W-1:0]               vl,
  input  logic                          vm,
  input  logic [MASK_W-1:0]             mask,
  input  logic [MAX_LMUL*VLEN_BITS-1:0] vs2_bus,
  input  logic [MAX_LMUL*VLEN_BITS-1:0] vs1_bus,
  input  logic [MAX_LMUL*VLEN_BITS-1:0] vd_old_bus,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MAX_LMUL*VLEN_BITS-1:0] vd_bus
);

  localparam int unsigned BW  = MAX_LMUL * VLEN_BITS;
  localparam int unsigned BIW = $clog2(BW);

  state_e               state_q, state_d;
  logic                 accept;
  logic [1:0]           cnt_q;
  logic [2:0]           op_q;
  logic                 sew_q;
  logic [1:0]           nreg_q;
  logic [VL_W-1:0]      vl_q;
  logic                 vm_q;
  logic [MASK_W-1:0]    mask_q;
  logic [BW-1:0]        vs2_q, vs1_q, vd_q;
  logic [BIW-1:0]       base;
  logic [VLEN_BITS-1:0] lane_res;

  assign base      = BIW'(32'(cnt_q) * VLEN_BITS);
  assign out_valid = (state_q == ST_DONE);
  assign vd_bus    = vd_q;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_BUSY: if (cnt_q == nreg_q) state_d = ST_DONE;
      ST_DONE: begin
        in_ready = out_ready;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    accept = in_valid & in_ready;
    if (accept) state_d = ST_BUSY;
  end

  // The old destination is copied in at accept; BUSY overwrites only the
  // chunks inside the group, so chunks above nreg keep vd_old_bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sew_q   <= '0;
      nreg_q  <= '0;
      vl_q    <= '0;
      vm_q    <= '0;
      mask_q  <= '0;
      vs2_q   <= '0;
      vs1_q   <= '0;
      vd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= op;
        sew_q  <= sew;
        nreg_q <= nreg;
        vl_q   <= vl;
        vm_q   <= vm;
        mask_q <= mask;
        vs2_q  <= vs2_bus;
        vs1_q  <= vs1_bus;
        vd_q   <= vd_old_bus;
        cnt_q  <= '0;
      end else if (state_q == ST_BUSY) begin
        vd_q[base +: VLEN_BITS] <= lane_res;
        cnt_q <= cnt_q + 2'd1;
      end
    end
  end

  vlogic_lane #(
    .VLEN_BITS(VLEN_BITS),
    .MASK_W   (MASK_W),
    .VL_W     (VL_W)
  ) u_lane (
    .op   (op_q),
    .sew  (sew_q),
    .chunk(cnt_q),
    .vl   (vl_q),
    .vm   (vm_q),
    .mask (mask_q),
    .vs2  (vs2_q[base +: VLEN_BITS]),
    .vs1  (vs1_q[base +: VLEN_BITS]),
    .old  (vd_q[base +: VLEN_BITS]),
    .res  (lane_res)
  );

endmodule

// File: tb/tb_vlogic_unit.sv
// Scoreboard bench for vlogic_unit: directed requests push hand-computed
// results and latencies; a monitor pops and checks on each out_valid rise.
module tb_vlogic_unit;
  import vlogic_pkg::*;

  localparam int unsigned BW = 512;
  localparam int unsigned MW = 64;
  localparam int unsigned VW = 7;

  logic          clk, rst, in_valid, in_ready, sew, vm, out_valid, out_ready;
  logic [2:0]    op;
  logic [1:0]    nreg;
  logic [VW-1:0] vl;
  logic [MW-1:0] mask;
  logic [BW-1:0] vs2_bus, vs1_bus, vd_old_bus, vd_bus;
  logic [BW-1:0] vo;

  vlogic_unit #(.VLEN_BITS(128), .MAX_LMUL(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .sew(sew), .nreg(nreg), .vl(vl), .vm(vm), .mask(mask),
    .vs2_bus(vs2_bus), .vs1_bus(vs1_bus), .vd_old_bus(vd_old_bus),
    .out_valid(out_valid), .out_ready(out_ready), .vd_bus(vd_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string         name;
    logic [BW-1:0] vd;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic fail_to(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got no handshake want one within bound", name);
  endtask

  // Monitor: compares each new result against the oldest pending expectation
  logic ov_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !ov_prev) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got out_valid 1 want no pending request");
      end else begin
        e = sb.pop_front();
        chk({e.name, "_vd"}, vd_bus, e.vd);
        chki({e.name, "_lat"}, cyc, e.cyc);
      end
    end
    ov_prev <= out_valid;
  end

  // Called just after a posedge; returns just after the handshake edge with
  // the request inputs scrambled, since they must be ignored from then on.
  task automatic issue(input string name, input logic [2:0] o, input logic s,
                       input logic [1:0] nr, input logic [VW-1:0] l, input logic m,
                       input logic [MW-1:0] mk, input logic [BW-1:0] a,
                       input logic [BW-1:0] b, input logic [BW-1:0] old,
                       input logic [BW-1:0] exp);
    exp_t e;
    bit done;
    done = 1'b0;
    op = o; sew = s; nreg = nr; vl = l; vm = m; mask = mk;
    vs2_bus = a; vs1_bus = b; vd_old_bus = old; in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.name = name;
        e.vd   = exp;
        e.cyc  = cyc + int'(nr) + 2;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    op = ~o; sew = ~s; nreg = ~nr; vl = ~l; vm = ~m; mask = ~mk;
    vs2_bus = ~a; vs1_bus = ~b; vd_old_bus = ~old;
    if (!done) fail_to({name, "_accept"});
  endtask

  task automatic wait_out(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) fail_to({name, "_done"});
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; sew = 1'b0; nreg = '0; vl = '0; vm = 1'b1; mask = '0;
    vs2_bus = '0; vs1_bus = '0; vd_old_bus = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chki("reset_out_valid", int'(out_valid), 0);
    chk("reset_vd", vd_bus, '0);
    chki("reset_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    vo = {16{32'h1357_9BDF}};
    issue("t1_xor", 3'b010, 1'b0, 2'd0, 7'd16, 1'b1, '0, {64{8'hA5}}, {64{8'h0F}},
          vo, {vo[BW-1:128], {16{8'hAA}}});
    wait_out("t1_xor");

    issue("t2_and", 3'b000, 1'b1, 2'd1, 7'd5, 1'b1, '0, '0, '0, {BW{1'b1}},
          {{352{1'b1}}, {160{1'b0}}});
    wait_out("t2_and");

    issue("t3_or_mask", 3'b001, 1'b0, 2'd0, 7'd16, 1'b0, 64'h5, '0, {64{8'h01}},
          {64{8'h77}}, {{61{8'h77}}, 8'h01, 8'h77, 8'h01});
    wait_out("t3_or_mask");

    issue("orn_vl_over", 3'b100, 1'b1, 2'd0, 7'd100, 1'b0, 64'h5, '0,
          {16{32'h0000_FFFF}}, '0, {384'b0, 32'h0, 32'hFFFF_0000, 32'h0, 32'hFFFF_0000});
    wait_out("orn_vl_over");

    issue("nand_vl20", 3'b110, 1'b0, 2'd1, 7'd20, 1'b1, '0, {BW{1'b1}}, {BW{1'b1}},
          {64{8'hEE}}, {{44{8'hEE}}, {160{1'b0}}});
    wait_out("nand_vl20");

    out_ready = 1'b0;
    issue("t4_nor", 3'b111, 1'b0, 2'd3, 7'd64, 1'b1, '0, {64{8'hF0}}, {64{8'h0C}},
          '0, {64{8'h03}});
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) fail_to("t4_nor_done");
    for (int k = 0; k < 5; k++) begin
      chki("t4_hold_valid", int'(out_valid), 1);
      chk("t4_hold_vd", vd_bus, {64{8'h03}});
      chki("t4_hold_in_ready", int'(in_ready), 0);
      if (k < 4) @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    issue("t4_xnor", 3'b101, 1'b1, 2'd0, 7'd4, 1'b1, '0, {16{32'hFFFF_0000}},
          {16{32'hFF00_FF00}}, '0, {384'b0, {4{32'hFF00_00FF}}});
    @(negedge clk);
    chki("t4_valid_drop", int'(out_valid), 0);
    wait_out("t4_xnor");

    issue("t5_abort", 3'b111, 1'b0, 2'd3, 7'd64, 1'b1, '0, {64{8'h11}}, {64{8'h22}},
          {64{8'h33}}, {64{8'hCC}});
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    if (sb.size() > 0) void'(sb.pop_back());
    @(negedge clk);
    chki("t5_rst_out_valid", int'(out_valid), 0);
    chk("t5_rst_vd", vd_bus, '0);
    chki("t5_rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    issue("t5_and", 3'b000, 1'b0, 2'd3, 7'd64, 1'b1, '0, {64{8'h3C}}, {64{8'h5A}},
          {64{8'hFF}}, {64{8'h18}});
    wait_out("t5_and");

    vo = {16{32'hDEAD_BEEF}};
    issue("t6_vl0", 3'b011, 1'b1, 2'd2, 7'd0, 1'b1, '0, {16{32'h1234_5678}},
          {16{32'h9ABC_DEF0}}, vo, vo);
    wait_out("t6_vl0");

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) fail_to("scoreboard_drain");
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vlogic_unit.md
Name: vlogic_unit

Overview:
Multi-cycle vector bitwise-logic unit, the parametrised successor to the single-cycle XOR datapath in the vector coprocessor execute stage.
- Supports 8 logic ops, SEW 8/32, register groups of 1..MAX_LMUL registers, vl tail handling and v0 masking (mask-undisturbed / tail-undisturbed).
- Processes one VLEN_BITS register chunk per cycle.
- Uses valid/ready handshakes on input and output.

Parameters:
VLEN_BITS, 128, bits per vector register
MAX_LMUL, 4, max registers per group; buses are MAX_LMUL*VLEN_BITS wide
MASK_W, MAX_LMUL*VLEN_BITS/8, mask bits (one per max element count)
VL_W, $clog2(MASK_W+1), vl width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  request valid
in_ready  out  1  unit can accept
op  in  3  000 AND, 001 OR, 010 XOR, 011 ANDN (vs2&~vs1), 100 ORN (vs2|~vs1), 101 XNOR, 110 NAND, 111 NOR
sew  in  1  0: 8-bit elements, 1: 32-bit elements
nreg  in  2  registers in group minus 1 (0..MAX_LMUL-1)
vl  in  VL_W  active element count
vm  in  1  1: unmasked, 0: masked by mask
mask  in  MASK_W  v0 bits; bit i governs global element i
vs2_bus  in  MAX_LMUL*VLEN_BITS  operand A
vs1_bus  in  MAX_LMUL*VLEN_BITS  operand B
vd_old_bus  in  MAX_LMUL*VLEN_BITS  old destination, for undisturbed elements
out_valid  out  1  result valid
out_ready  in  1  consumer accepts
vd_bus  out  MAX_LMUL*VLEN_BITS  result (registered)

Behaviour:
- States are IDLE, BUSY and DONE. Reset goes to IDLE with chunk counter 0, out_valid 0, vd_bus 0 and all latched operands 0.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational from state and out_ready, so it is 1 in the first cycle after reset.
- Accept when in_valid & in_ready:
  - latch op, sew, nreg, vl, vm, mask, vs2, vs1;
  - load the result register with vd_old_bus;
  - counter=0; go to BUSY.
- In BUSY, at each edge, write chunk c=counter of the result register from the lane output, then counter++. After the chunk c==nreg write, go to DONE.
- out_valid=1 exactly in DONE. Latency: out_valid is first high nreg+2 cycles after the handshake cycle.
- DONE & out_ready & !in_valid -> IDLE. DONE & out_ready & in_valid -> accept the new request, go directly to BUSY; out_valid drops.
- While out_valid is high and out_ready is low, vd_bus is held stable.
- Chunks above nreg are never written and keep vd_old_bus.
- Element rules. Global index g = c*(VLEN_BITS/SEW) + j. Element active iff g<vl and (vm | mask[g]).
  - Active: op result.
  - Inactive (masked-off body or tail): keep vd_old.
  - vl beyond group capacity: all group elements active (subject to mask).
  - vl==0: result equals vd_old; latency unchanged.
- Inputs other than in_valid are ignored outside the accept cycle.
- rst asserted in any state, including mid-BUSY or DONE, aborts the operation: next cycle IDLE, out_valid 0, vd_bus 0; the in-flight result is discarded.

Decomposition:
- Package vlogic_pkg:
  - op encodings (VLOG_AND..VLOG_NOR);
  - SEW encodings (SEW_8=0, SEW_32=1);
  - state enum;
  - width functions for MASK_W and VL_W.
- Sub-module vlogic_lane: combinational, one VLEN_BITS chunk.
  - Inputs: op, sew, chunk index, vl, vm, mask, vs2/vs1/old chunk.
  - Output: result chunk.
  - Builds the per-byte write enable from the active-element rule (32-bit elements replicate their enable over 4 bytes).
- The top level holds the FSM, counter and result register.

Test Plan:
1. XOR, sew=0, nreg=0, vl=16, vm=1, vs2 bytes 0xA5, vs1 bytes 0x0F -> chunk0 all 0xAA, chunks1-3 = vd_old; out_valid first high 2 cycles after the handshake.
2. AND, sew=1, nreg=1, vl=5, vs2=vs1=0, vd_old all 0xFFFFFFFF -> words 0-4 = 0, words 5-7 = 0xFFFFFFFF, chunks2-3 unchanged; latency 3.
3. OR, sew=0, nreg=0, vm=0, mask=0x5, vl=16, vs1 bytes 0x01, vs2=0, vd_old bytes 0x77 -> bytes 0,2 = 0x01, all others 0x77.
4. nreg=3 NOR, out_ready low 5 cycles -> out_valid and vd_bus stable, in_ready 0. Then out_ready=1 with in_valid=1 in the same cycle -> new request accepted, out_valid low next cycle.
5. rst pulsed during BUSY chunk 2 of nreg=3 -> next cycle out_valid 0, vd_bus 0, in_ready 1. A fresh request then completes normally.
6. vl=0, ANDN, any operands -> vd_bus == vd_old_bus; latency nreg+2.
